// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment driver.
// Segment patterns are active-high with bit 0 = segment a, bit 6 = segment g.
package fnd_pkg;

    // All segments dark, active-high form.
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Hex glyphs 0..F, active-high, {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_PATTERN [16] = '{
        7'b0111111,  // 0
        7'b0000110,  // 1
        7'b1011011,  // 2
        7'b1001111,  // 3
        7'b1100110,  // 4
        7'b1101101,  // 5
        7'b1111101,  // 6
        7'b0000111,  // 7
        7'b1111111,  // 8
        7'b1101111,  // 9
        7'b1110111,  // A
        7'b1111100,  // b
        7'b0111001,  // C
        7'b1011110,  // d
        7'b1111001,  // E
        7'b1110001   // F
    };

    // Convert an active-high pattern to the board's pin polarity.
    function automatic logic [6:0] seg_polarity(input logic [6:0] pattern,
                                                input logic       active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/fnd_hex_decoder.sv
// Combinational nibble-to-glyph decoder; a blanked digit shows no segments.
module fnd_hex_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    // Table lookup, overridden to dark when the digit is blanked.
    always_comb begin
        seg = SEG_PATTERN[nibble];
        if (blank) begin
            seg = SEG_OFF;
        end
    end

endmodule

// File: rtl/fnd_scan_driver.sv
// Time-multiplexed FND scan driver. A prescaler paces one digit slot of
// CLK_DIV cycles; the digit index walks 0..NUM_DIGITS-1. Loads land in a
// shadow copy and are promoted to the display copy only at frame boundaries
// (or continuously while scanning is disabled), so a frame never tears.
// All outputs come from one register stage driven by the current index and
// display copy, so segments, dp and commons always switch together.
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit COM_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              fnd,
    output logic                    fnd_dp,
    output logic [NUM_DIGITS-1:0]   fnd_com,
    output logic                    frame_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    localparam logic [PW-1:0]         PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0]         IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            FND_IDLE  = seg_polarity(SEG_OFF, SEG_ACTIVE_LOW);
    localparam logic [NUM_DIGITS-1:0] COM_IDLE  = {NUM_DIGITS{COM_ACTIVE_LOW}};

    // Scan counters
    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  bnd_q, bnd_d;

    // Shadow (load target) and display (decoder source) copies
    logic [VW-1:0]         shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic                  shadow_blz_q, shadow_blz_d;
    logic [VW-1:0]         disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic                  disp_blz_q, disp_blz_d;

    // Registered pin drivers
    logic [6:0]            fnd_q, fnd_d;
    logic                  fnd_dp_q, fnd_dp_d;
    logic [NUM_DIGITS-1:0] fnd_com_q, fnd_com_d;
    logic                  frame_done_q, frame_done_d;

    // Current-digit selection
    logic [3:0]            nib_cur;
    logic                  blank_cur;
    logic                  dp_cur;
    logic                  hi_zero;
    logic [NUM_DIGITS-1:0] com_sel;
    logic [6:0]            seg_cur;

    fnd_hex_decoder u_dec (
        .nibble (nib_cur),
        .blank  (blank_cur),
        .seg    (seg_cur)
    );

    // Prescaler/index advance, shadow capture and frame-boundary promotion.
    always_comb begin
        presc_d      = presc_q;
        idx_d        = idx_q;
        bnd_d        = 1'b0;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        shadow_blz_d = shadow_blz_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        disp_blz_d   = disp_blz_q;

        if (load) begin
            shadow_val_d = value;
            shadow_dp_d  = dp_in;
            shadow_blz_d = blank_lz;
        end

        if (!enable) begin
            presc_d = '0;
            idx_d   = '0;
        end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            if (idx_q == IDX_MAX) begin
                idx_d = '0;
                bnd_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            presc_d = presc_q + 1'b1;
        end

        // A load in the promotion cycle bypasses the shadow so it is not lost
        // behind the old shadow contents.
        if (!enable || bnd_d) begin
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp_in;
                disp_blz_d = blank_lz;
            end else begin
                disp_val_d = shadow_val_q;
                disp_dp_d  = shadow_dp_q;
                disp_blz_d = shadow_blz_q;
            end
        end
    end

    // Pick the lit digit's nibble/dp and decide leading-zero blanking by
    // walking from the most significant digit down.
    always_comb begin
        nib_cur   = 4'h0;
        blank_cur = 1'b0;
        dp_cur    = 1'b0;
        hi_zero   = 1'b1;
        com_sel   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            hi_zero = hi_zero & (disp_val_q[i*4 +: 4] == 4'h0);
            if (idx_q == IW'(i)) begin
                nib_cur    = disp_val_q[i*4 +: 4];
                blank_cur  = disp_blz_q & (i != 0) & hi_zero;
                dp_cur     = disp_dp_q[i];
                com_sel[i] = 1'b1;
            end
        end
    end

    // Pin values for the next cycle: dark while disabled, else the indexed digit.
    always_comb begin
        fnd_d        = FND_IDLE;
        fnd_dp_d     = SEG_ACTIVE_LOW;
        fnd_com_d    = COM_IDLE;
        frame_done_d = 1'b0;
        if (enable) begin
            fnd_d        = seg_polarity(seg_cur, SEG_ACTIVE_LOW);
            fnd_dp_d     = dp_cur ^ SEG_ACTIVE_LOW;
            fnd_com_d    = COM_ACTIVE_LOW ? ~com_sel : com_sel;
            frame_done_d = bnd_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            bnd_q        <= 1'b0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            shadow_blz_q <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_blz_q   <= 1'b0;
            fnd_q        <= FND_IDLE;
            fnd_dp_q     <= SEG_ACTIVE_LOW;
            fnd_com_q    <= COM_IDLE;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            bnd_q        <= bnd_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            shadow_blz_q <= shadow_blz_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            disp_blz_q   <= disp_blz_d;
            fnd_q        <= fnd_d;
            fnd_dp_q     <= fnd_dp_d;
            fnd_com_q    <= fnd_com_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign fnd        = fnd_q;
    assign fnd_dp     = fnd_dp_q;
    assign fnd_com    = fnd_com_q;
    assign frame_done = frame_done_q;

endmodule
